pcpi_issue_ctrl: RTL and testbench
==================================

Name: pcpi_issue_ctrl

Overview:
- Initiator (core-side) end of the PCPI coprocessor interface.
- Accepts one offloaded instruction plus its operands from the decode/execute stage and drives pcpi_valid/insn/rs1/rs2 to the attached coprocessors (mul, div, ...).
- Waits for pcpi_ready, or declares the instruction illegal if no coprocessor claims it within a timeout.
- Returns the result to writeback through a valid/ready response channel.

Parameters:
- TIMEOUT_CYCLES, 16: consecutive issue cycles with pcpi_wait and pcpi_ready both low before declaring illegal; legal range 4..255.
- ENABLE_TIMEOUT, 1: 0 = never time out; wait indefinitely for pcpi_ready.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- req_valid  in  1  request from core
- req_ready  out  1  controller can accept a request
- req_insn  in  32  instruction word
- req_rs1  in  32  operand 1
- req_rs2  in  32  operand 2
- req_rd_addr  in  5  destination register index
- pcpi_valid  out  1  instruction offered to coprocessors
- pcpi_insn  out  32  registered copy of req_insn
- pcpi_rs1  out  32  registered copy of req_rs1
- pcpi_rs2  out  32  registered copy of req_rs2
- pcpi_wr  in  1  coprocessor writes a result
- pcpi_rd  in  32  coprocessor result
- pcpi_wait  in  1  a coprocessor has claimed the instruction and is busy
- pcpi_ready  in  1  coprocessor done; pcpi_wr and pcpi_rd are valid this cycle
- rsp_valid  out  1  response available
- rsp_ready  in  1  writeback accepts the response
- rsp_wr  out  1  write rsp_rd to rsp_rd_addr
- rsp_rd  out  32  result
- rsp_rd_addr  out  5  destination register index
- rsp_illegal  out  1  no coprocessor claimed the instruction
- busy  out  1  state != IDLE

Behaviour:
- Reset (resetn low at a clk edge):
  - State goes to IDLE.
  - pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, rsp_valid, rsp_wr, rsp_rd, rsp_rd_addr, rsp_illegal all 0.
  - Timeout counter 0.
  - req_ready is forced 0 while resetn is low.
  - Reset mid-operation aborts silently: no response is produced, and any late pcpi_ready is ignored.
- States: IDLE, ISSUE, RESP.
- req_ready = resetn && state==IDLE (combinational). busy = state!=IDLE.
- IDLE:
  - On req_valid && req_ready, latch insn/rs1/rs2/rd_addr, load counter = TIMEOUT_CYCLES, go to ISSUE.
  - pcpi_valid goes high the next cycle (1-cycle issue latency).
- ISSUE:
  - pcpi_valid=1. pcpi_insn/rs1/rs2 stay stable for the whole ISSUE period.
  - Priority per cycle is ready > wait > count.
  - pcpi_ready=1: capture rsp_wr=pcpi_wr; rsp_rd=pcpi_wr ? pcpi_rd : 0; rsp_illegal=0; go to RESP. pcpi_valid drops next cycle.
  - Else pcpi_wait=1: reload counter to TIMEOUT_CYCLES; stay in ISSUE.
  - Else, if ENABLE_TIMEOUT and counter==1: rsp_illegal=1, rsp_wr=0, rsp_rd=0; go to RESP.
  - Else, if ENABLE_TIMEOUT: decrement counter.
  - With no responder, pcpi_valid is high exactly TIMEOUT_CYCLES cycles.
  - pcpi_ready arriving in the same cycle the counter would expire counts as success, not illegal.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_ready, go to IDLE next cycle.
  - req_ready stays 0 during RESP, so there is no same-cycle re-accept.
  - Minimum spacing between accepts: 3 cycles.
- rsp_valid rises one cycle after the cycle in which pcpi_ready is sampled high.
- pcpi_wr/pcpi_rd are sampled only when pcpi_ready=1; they are ignored at all other times, including in IDLE and RESP.
- Counter width is 8 bits.

Test Plan:
- DIV x1=100, x2=7, insn 0x0220C533 (rd=x10), rsp_ready=1 with a div coprocessor attached -> pcpi_valid high from accept+1 until the cycle after pcpi_ready. rsp_valid for 1 cycle with rsp_wr=1, rsp_rd=14, rsp_rd_addr=10, rsp_illegal=0.
- Unclaimed insn 0x0000000B, no coprocessor (wait/ready tied 0), TIMEOUT_CYCLES=16 -> pcpi_valid high exactly 16 cycles. Then rsp_valid=1, rsp_illegal=1, rsp_wr=0, rsp_rd=0.
- pcpi_wait asserted on issue cycle 3 and held 40 cycles, then pcpi_ready with pcpi_wr=1, pcpi_rd=0xDEADBEEF -> no timeout. rsp_rd=0xDEADBEEF.
- pcpi_ready=1 with pcpi_wr=0, pcpi_rd=0x12345678 exactly on the would-expire cycle -> rsp_illegal=0, rsp_wr=0, rsp_rd=0.
- Backpressure: rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready=0, new req_valid not accepted. Accept occurs only after the response handshake and return to IDLE.
- resetn pulsed low during ISSUE while pcpi_wait=1 -> next cycle all outputs 0, and a subsequent pcpi_ready produces no rsp_valid.

Source files
------------

// File: rtl/pcpi_issue_ctrl_if.sv
// PCPI issue controller bus bundle.
// Request, coprocessor and response channels.
interface pcpi_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_insn;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd_addr;

  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_wr;
  logic [31:0] rsp_rd;
  logic [4:0]  rsp_rd_addr;
  logic        rsp_illegal;

  modport master (
    input  req_valid, req_insn, req_rs1,
    input  req_rs2, req_rd_addr,
    output req_ready,
    output pcpi_valid, pcpi_insn,
    output pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd,
    input  pcpi_wait, pcpi_ready,
    output rsp_valid, rsp_wr, rsp_rd,
    output rsp_rd_addr, rsp_illegal,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_insn, req_rs1,
    output req_rs2, req_rd_addr,
    input  req_ready,
    input  pcpi_valid, pcpi_insn,
    input  pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd,
    output pcpi_wait, pcpi_ready,
    input  rsp_valid, rsp_wr, rsp_rd,
    input  rsp_rd_addr, rsp_illegal,
    output rsp_ready
  );
endinterface

// File: rtl/pcpi_issue_ctrl.sv
// PCPI initiator: issues one offloaded insn,
// waits for a claim or times out, returns result.
module pcpi_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit ENABLE_TIMEOUT = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  pcpi_issue_ctrl_if.master bus,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pv_q, pv_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic        rv_q, rv_d;
  logic        rwr_q, rwr_d;
  logic [31:0] rrd_q, rrd_d;
  logic [4:0]  rda_q, rda_d;
  logic        ill_q, ill_d;

  assign bus.req_ready   = resetn && (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign bus.pcpi_valid  = pv_q;
  assign bus.pcpi_insn   = insn_q;
  assign bus.pcpi_rs1    = rs1_q;
  assign bus.pcpi_rs2    = rs2_q;
  assign bus.rsp_valid   = rv_q;
  assign bus.rsp_wr      = rwr_q;
  assign bus.rsp_rd      = rrd_q;
  assign bus.rsp_rd_addr = rda_q;
  assign bus.rsp_illegal = ill_q;

  // Next-state: accept, issue with ready>wait>count, respond.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pv_d    = pv_q;
    insn_d  = insn_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rv_d    = rv_q;
    rwr_d   = rwr_q;
    rrd_d   = rrd_q;
    rda_d   = rda_q;
    ill_d   = ill_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          insn_d  = bus.req_insn;
          rs1_d   = bus.req_rs1;
          rs2_d   = bus.req_rs2;
          rda_d   = bus.req_rd_addr;
          cnt_d   = TMO;
          pv_d    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.pcpi_ready) begin
          rwr_d   = bus.pcpi_wr;
          rrd_d   = bus.pcpi_wr ? bus.pcpi_rd : '0;
          ill_d   = 1'b0;
          rv_d    = 1'b1;
          pv_d    = 1'b0;
          state_d = RESP;
        end else if (bus.pcpi_wait) begin
          cnt_d = TMO;
        end else if (ENABLE_TIMEOUT && cnt_q == 8'd1) begin
          rwr_d   = 1'b0;
          rrd_d   = '0;
          ill_d   = 1'b1;
          rv_d    = 1'b1;
          pv_d    = 1'b0;
          state_d = RESP;
        end else if (ENABLE_TIMEOUT) begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pv_q    <= 1'b0;
      insn_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rv_q    <= 1'b0;
      rwr_q   <= 1'b0;
      rrd_q   <= '0;
      rda_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pv_q    <= pv_d;
      insn_q  <= insn_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rv_q    <= rv_d;
      rwr_q   <= rwr_d;
      rrd_q   <= rrd_d;
      rda_q   <= rda_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// Bench for pcpi_issue_ctrl: vector table,
// random transactions vs. a cycle-count model.
module tb_pcpi_issue_ctrl;

  localparam int T = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy, busy2;

  always #5 clk = ~clk;

  pcpi_issue_ctrl_if bus ();
  pcpi_issue_ctrl_if bus2 ();

  pcpi_issue_ctrl #(
    .TIMEOUT_CYCLES(T),
    .ENABLE_TIMEOUT(1'b1)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .busy(busy)
  );

  pcpi_issue_ctrl #(
    .TIMEOUT_CYCLES(4),
    .ENABLE_TIMEOUT(1'b0)
  ) dut2 (
    .clk(clk),
    .resetn(resetn),
    .bus(bus2),
    .busy(busy2)
  );

  typedef struct {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    int          ws;
    int          wl;
    int          ra;
    logic        wr;
    logic [31:0] rv;
    int          bp;
    logic        e_ill;
    logic        e_wr;
    logic [31:0] e_rd;
    int          e_cyc;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    logic [31:0] insn, logic [31:0] rs1,
    logic [31:0] rs2, logic [4:0] rd,
    int ws, int wl, int ra,
    logic wr, logic [31:0] rv, int bp,
    logic e_ill, logic e_wr,
    logic [31:0] e_rd, int e_cyc);
    vec_t v;
    v.insn = insn; v.rs1 = rs1; v.rs2 = rs2;
    v.rd = rd; v.ws = ws; v.wl = wl; v.ra = ra;
    v.wr = wr; v.rv = rv; v.bp = bp;
    v.e_ill = e_ill; v.e_wr = e_wr;
    v.e_rd = e_rd; v.e_cyc = e_cyc;
    return v;
  endfunction

  // Outcome from the rules: the insn is illegal
  // once T cycles pass since the last wait (or
  // issue start) with no ready; ready wins.
  function automatic vec_t model(input vec_t vi);
    vec_t v = vi;
    int last = 0;
    for (int c = 1; c <= 1000; c++) begin
      if (v.ra == c) begin
        v.e_ill = 1'b0;
        v.e_wr = v.wr;
        v.e_rd = v.wr ? v.rv : 32'd0;
        v.e_cyc = c;
        return v;
      end
      if (c >= v.ws && c < v.ws + v.wl) begin
        last = c;
      end else if (c - last >= T) begin
        v.e_ill = 1'b1;
        v.e_wr = 1'b0;
        v.e_rd = 32'd0;
        v.e_cyc = c;
        return v;
      end
    end
    return v;
  endfunction

  task automatic do_txn(input vec_t v,
                        input string tag);
    int c = 0;
    bit stab = 1'b1;
    bit hold = 1'b1;
    bit rsp_ok;
    @(negedge clk);
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_insn = v.insn;
    bus.req_rs1 = v.rs1;
    bus.req_rs2 = v.rs2;
    bus.req_rd_addr = v.rd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_insn = $urandom;
    bus.req_rs1 = $urandom;
    bus.req_rs2 = $urandom;
    bus.req_rd_addr = 5'($urandom);
    while (bus.pcpi_valid === 1'b1) begin
      c++;
      if (c > 400) break;
      stab &= (bus.pcpi_insn == v.insn) &&
              (bus.pcpi_rs1 == v.rs1) &&
              (bus.pcpi_rs2 == v.rs2);
      hold &= (bus.req_ready == 1'b0) &&
              (busy == 1'b1);
      bus.pcpi_wait = (c >= v.ws) &&
                      (c < v.ws + v.wl);
      bus.pcpi_ready = (c == v.ra);
      bus.pcpi_wr = (c == v.ra) ? v.wr :
                    1'($urandom);
      bus.pcpi_rd = (c == v.ra) ? v.rv :
                    $urandom;
      @(negedge clk);
    end
    bus.pcpi_wait = 1'b0;
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wr = 1'($urandom);
    bus.pcpi_rd = $urandom;
    chk({tag, ".valid_cycles"}, c, v.e_cyc);
    chk({tag, ".operands_stable"}, 32'(stab), 1);
    chk({tag, ".issue_busy"}, 32'(hold), 1);
    if (c > 400) begin
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      return;
    end
    for (int i = 0; i <= v.bp; i++) begin
      rsp_ok = (bus.rsp_valid == 1'b1) &&
               (bus.rsp_wr == v.e_wr) &&
               (bus.rsp_rd == v.e_rd) &&
               (bus.rsp_rd_addr == v.rd) &&
               (bus.rsp_illegal == v.e_ill);
      if (!rsp_ok) begin
        chk({tag, ".rsp_valid"},
            32'(bus.rsp_valid), 1);
        chk({tag, ".rsp_wr"},
            32'(bus.rsp_wr), 32'(v.e_wr));
        chk({tag, ".rsp_rd"}, bus.rsp_rd, v.e_rd);
        chk({tag, ".rsp_rd_addr"},
            32'(bus.rsp_rd_addr), 32'(v.rd));
        chk({tag, ".rsp_illegal"},
            32'(bus.rsp_illegal), 32'(v.e_ill));
      end else begin
        chk({tag, ".rsp_bundle"}, 32'(rsp_ok), 1);
      end
      chk({tag, ".resp_req_ready"},
          32'(bus.req_ready), 0);
      bus.req_valid = (i < v.bp);
      bus.rsp_ready = (i == v.bp);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk({tag, ".rsp_drop"}, 32'(bus.rsp_valid), 0);
    chk({tag, ".idle_busy"}, 32'(busy), 0);
    chk({tag, ".no_accept"},
        32'(bus.pcpi_valid), 0);
  endtask

  vec_t tbl[9];
  vec_t rv;
  bit flag;

  initial begin
    bus.req_valid = 0; bus.req_insn = 0;
    bus.req_rs1 = 0; bus.req_rs2 = 0;
    bus.req_rd_addr = 0; bus.pcpi_wr = 0;
    bus.pcpi_rd = 0; bus.pcpi_wait = 0;
    bus.pcpi_ready = 0; bus.rsp_ready = 0;
    bus2.req_valid = 0; bus2.req_insn = 0;
    bus2.req_rs1 = 0; bus2.req_rs2 = 0;
    bus2.req_rd_addr = 0; bus2.pcpi_wr = 0;
    bus2.pcpi_rd = 0; bus2.pcpi_wait = 0;
    bus2.pcpi_ready = 0; bus2.rsp_ready = 1;

    tbl[0] = mk(32'h0220C533, 100, 7, 10,
                0, 0, 3, 1, 14, 0,
                0, 1, 14, 3);
    tbl[1] = mk(32'h0000000B, 1, 2, 3,
                0, 0, 0, 0, 0, 0,
                1, 0, 0, 16);
    tbl[2] = mk(32'h02B505B3, 5, 6, 7,
                3, 40, 43, 1, 32'hDEADBEEF, 0,
                0, 1, 32'hDEADBEEF, 43);
    tbl[3] = mk(32'h02C60633, 8, 9, 12,
                0, 0, 16, 0, 32'h12345678, 0,
                0, 0, 0, 16);
    tbl[4] = mk(32'h02D686B3, 3, 4, 13,
                0, 0, 2, 1, 32'h55, 5,
                0, 1, 32'h55, 2);
    tbl[5] = mk(32'h0000100B, 11, 12, 14,
                1, 5, 0, 1, 32'h99, 1,
                1, 0, 0, 21);
    tbl[6] = mk(32'h02E70733, 32'hFFFF0000,
                32'h1, 31,
                0, 0, 1, 1, 32'hFFFFFFFF, 0,
                0, 1, 32'hFFFFFFFF, 1);
    tbl[7] = mk(32'h0000200B, 15, 16, 17,
                10, 1, 0, 0, 0, 2,
                1, 0, 0, 26);
    tbl[8] = mk(32'h02F787B3, 20, 21, 18,
                2, 5, 4, 1, 32'h77, 0,
                0, 1, 32'h77, 4);

    // Reset values.
    repeat (3) @(negedge clk);
    flag = (bus.pcpi_valid == 0) &&
           (bus.pcpi_insn == 0) &&
           (bus.pcpi_rs1 == 0) &&
           (bus.pcpi_rs2 == 0) &&
           (bus.rsp_valid == 0) &&
           (bus.rsp_wr == 0) &&
           (bus.rsp_rd == 0) &&
           (bus.rsp_rd_addr == 0) &&
           (bus.rsp_illegal == 0) &&
           (busy == 0);
    chk("reset.outputs", 32'(flag), 1);
    chk("reset.req_ready", 32'(bus.req_ready), 0);
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_txn(tbl[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 25; i++) begin
      rv.insn = $urandom;
      rv.rs1 = $urandom;
      rv.rs2 = $urandom;
      rv.rd = 5'($urandom_range(1, 31));
      rv.ws = $urandom_range(1, 20);
      rv.wl = $urandom_range(0, 30);
      rv.ra = ($urandom_range(0, 3) == 0) ? 0 :
              $urandom_range(1, 45);
      rv.wr = 1'($urandom);
      rv.rv = $urandom;
      rv.bp = $urandom_range(0, 3);
      rv = model(rv);
      do_txn(rv, $sformatf("rnd%0d", i));
    end

    // Reset during ISSUE with wait held high.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_insn = 32'h02A5D5B3;
    bus.req_rs1 = 32'h11;
    bus.req_rs2 = 32'h22;
    bus.req_rd_addr = 5'd9;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.pcpi_wait = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.pre_valid", 32'(bus.pcpi_valid), 1);
    resetn = 1'b0;
    @(negedge clk);
    flag = (bus.pcpi_valid == 0) &&
           (bus.pcpi_insn == 0) &&
           (bus.pcpi_rs1 == 0) &&
           (bus.pcpi_rs2 == 0) &&
           (bus.rsp_valid == 0) &&
           (bus.rsp_wr == 0) &&
           (bus.rsp_rd == 0) &&
           (bus.rsp_rd_addr == 0) &&
           (bus.rsp_illegal == 0) &&
           (busy == 0);
    chk("rst.outputs", 32'(flag), 1);
    chk("rst.req_ready", 32'(bus.req_ready), 0);
    resetn = 1'b1;
    bus.pcpi_wait = 1'b0;
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr = 1'b1;
    bus.pcpi_rd = 32'hCAFEF00D;
    @(negedge clk);
    bus.pcpi_ready = 1'b0;
    chk("rst.late_ready", 32'(bus.rsp_valid), 0);
    chk("rst.idle", 32'(busy), 0);
    chk("rst.req_ready_back",
        32'(bus.req_ready), 1);
    @(negedge clk);
    chk("rst.no_rsp", 32'(bus.rsp_valid), 0);

    // Timeout disabled: waits indefinitely.
    bus2.req_valid = 1'b1;
    bus2.req_insn = 32'h0000300B;
    bus2.req_rd_addr = 5'd5;
    @(negedge clk);
    bus2.req_valid = 1'b0;
    flag = 1'b1;
    for (int i = 0; i < 40; i++) begin
      flag &= (bus2.pcpi_valid == 1'b1) &&
              (bus2.rsp_valid == 1'b0);
      @(negedge clk);
    end
    chk("notmo.still_issuing", 32'(flag), 1);
    bus2.pcpi_ready = 1'b1;
    bus2.pcpi_wr = 1'b1;
    bus2.pcpi_rd = 32'hA5A5;
    @(negedge clk);
    bus2.pcpi_ready = 1'b0;
    chk("notmo.pcpi_drop",
        32'(bus2.pcpi_valid), 0);
    chk("notmo.rsp_valid", 32'(bus2.rsp_valid), 1);
    chk("notmo.rsp_illegal",
        32'(bus2.rsp_illegal), 0);
    chk("notmo.rsp_rd", bus2.rsp_rd, 32'hA5A5);
    chk("notmo.rsp_rd_addr",
        32'(bus2.rsp_rd_addr), 5);
    @(negedge clk);
    chk("notmo.done", 32'(bus2.rsp_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
